classifier_aging: RTL and testbench
===================================

# classifier_aging

Flow-table aging engine for the classifier. It keeps a valid bit and an age counter per flow entry. Lookup hits and new-flow learns refresh entries, and a periodic sweep ages them against the programmable `aging_time` threshold from the classifier register block. Expired entries are invalidated and reported downstream, one at a time, through a valid/ready handshake so the hash-table manager can delete them.

## Interface
- `FLOW_ADDR_NBITS`, default 10: flow-table address width; the table has 2^FLOW_ADDR_NBITS entries.
- `AGE_NBITS`, default `AGING_TIME_NBITS`: width of the per-entry age counter and of `aging_time`.

- `clk`  in  1  block clock; the single clock.
- `rst`  in  1  asynchronous, active-high reset; port declared through `RESET_SIG`, tested with `ACTIVE_RESET`.
- `aging_time`  in  AGE_NBITS  expiry threshold, in sweeps; sampled live.
- `tick`  in  1  single-cycle sweep request pulse.
- `hit_valid`  in  1  lookup hit; refreshes `hit_addr`.
- `hit_addr`  in  FLOW_ADDR_NBITS  hit entry.
- `learn_valid`  in  1  new flow installed at `learn_addr`.
- `learn_addr`  in  FLOW_ADDR_NBITS  learned entry.
- `aged_valid`  out  1  expired-entry notification valid.
- `aged_addr`  out  FLOW_ADDR_NBITS  expired entry address.
- `aged_ready`  in  1  downstream accepts the notification.
- `init_done`  out  1  table clear complete.
- `busy`  out  1  sweep in progress.
- `overrun`  out  1  sticky; a tick was dropped.
- `aged_cnt`  out  32  count of expired entries.

## Operation
- Internal entry array, one per flow: valid bit plus age[AGE_NBITS-1:0].
- FSM states: INIT, IDLE, READ, UPDATE, NOTIFY.
- **INIT** (after reset)
  - Writes valid=0, age=0 to entries 0..2^N-1, one per cycle.
  - Then sets `init_done`=1 and enters IDLE.
  - Hits, learns and ticks are ignored during INIT.
- **Refresh path** (any state except INIT)
  - Learn: valid=1, age=0.
  - Hit: age=0 if the entry is valid; a hit on an invalid entry is ignored.
  - `hit_valid` and `learn_valid` are mutually exclusive by contract, because they come from the same lookup stage.
- **Tick**
  - In IDLE: start a sweep at address 0, `busy`=1.
  - During a sweep: set a one-deep pending flag.
  - Tick while pending is already set: dropped, `overrun`=1 (sticky until reset).
- **READ**: registered read of the entry at the sweep pointer; clear the `refreshed` flag.
- **UPDATE**
  - If a hit or learn matched the pointer during READ or this cycle (`refreshed`): no write, next entry.
  - Else if a hit or learn to another address is present this cycle: stall in UPDATE, since the array has one write port and refresh wins.
  - Else if valid and age ≥ `aging_time`: write valid=0, go to NOTIFY.
  - Else if valid: age+1. No saturation is needed, because age < `aging_time` ≤ max.
  - Invalid entries: no write.
- **NOTIFY**
  - `aged_valid`=1, `aged_addr`=pointer, held stable until `aged_ready`.
  - On the handshake cycle: `aged_cnt`+1 and advance to the next entry.
- **End of sweep**
  - After the last entry (pointer wrap to 0): if pending, clear it and start a new sweep immediately (READ).
  - Else go to IDLE with `busy`=0.
- `aging_time`=0: every valid entry expires on the next sweep.

## Timing
- Reset values:
  - `aged_valid`=0, `aged_addr`=0, `init_done`=0, `busy`=0, `overrun`=0, `aged_cnt`=0.
  - Sweep pointer 0, pending 0, state INIT.
- INIT takes 2^N cycles; `init_done` rises on cycle 2^N after reset release.
- Tick-to-`busy`: 1 cycle. An entry with no stalls costs 2 cycles; an expired entry costs 3 + (cycles waiting for `aged_ready`).
- `aged_valid` asserts the cycle after the expiring UPDATE. Handshake completes when `aged_valid`&`aged_ready` are both high at a clock edge; `aged_valid` may be high again 2 cycles later at the earliest.
- Refresh writes take effect at the next edge and are visible to a READ issued in the following cycle.
- Reset mid-sweep or mid-NOTIFY: abort immediately, drop any notification, re-run INIT.

## Configuration
- `CLASSIFIER_AGING_STATS_EN`
  - Defined: `aged_cnt` (wrapping 32-bit) and `overrun` are implemented as described.
  - Undefined: both outputs are tied to 0, and the counter and sticky logic are not built.
  - Ports exist in both cases.

## Test plan
Bench uses FLOW_ADDR_NBITS=4 and AGE_NBITS=4.
- **Reset / INIT:** release reset -> `init_done`=1 exactly 16 cycles later; all outputs at their reset values until then.
- **Expiry:** learn addr 5, `aging_time`=2, three ticks with `aged_ready`=1 -> exactly one `aged_valid` with `aged_addr`=5, during the third sweep; `aged_cnt`=1.
- **Hit refresh:** learn addr 3, `aging_time`=1, a hit to addr 3 before each of four ticks -> no notification; entry 3 still valid.
- **Backpressure:** expire addrs 2 and 9 with `aged_ready`=0 for 20 cycles -> `aged_valid` held with `aged_addr`=2 and the sweep stalled; raise ready -> 2 then 9 delivered, `aged_cnt`=2.
- **Tick overload:** three ticks 1 cycle apart from IDLE -> two back-to-back sweeps, `overrun`=1; without `CLASSIFIER_AGING_STATS_EN`, `overrun`=0.
- **Refresh race:** a hit to the entry being read in the same cycle as its READ, with age = `aging_time` -> entry not expired, and its age is 0 afterwards.

Source files
------------

// File: rtl/classifier_aging.sv
// classifier_aging: per-flow valid/age table with refresh, periodic aging sweep and expiry notification.
// Optional statistics outputs (aged_cnt, overrun) are built only when CLASSIFIER_AGING_STATS_EN is defined.

`ifndef AGING_TIME_NBITS
`define AGING_TIME_NBITS 16
`endif

module classifier_aging #(
    parameter int FLOW_ADDR_NBITS = 10,
    parameter int AGE_NBITS       = `AGING_TIME_NBITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AGE_NBITS-1:0]       aging_time,
    input  logic                       tick,
    input  logic                       hit_valid,
    input  logic [FLOW_ADDR_NBITS-1:0] hit_addr,
    input  logic                       learn_valid,
    input  logic [FLOW_ADDR_NBITS-1:0] learn_addr,
    output logic                       aged_valid,
    output logic [FLOW_ADDR_NBITS-1:0] aged_addr,
    input  logic                       aged_ready,
    output logic                       init_done,
    output logic                       busy,
    output logic                       overrun,
    output logic [31:0]                aged_cnt
);

    localparam int DEPTH = 1 << FLOW_ADDR_NBITS;
    localparam logic [FLOW_ADDR_NBITS-1:0] LAST_ADDR = {FLOW_ADDR_NBITS{1'b1}};
    localparam logic [FLOW_ADDR_NBITS-1:0] ADDR_ONE  = {{(FLOW_ADDR_NBITS-1){1'b0}}, 1'b1};
    localparam logic [AGE_NBITS-1:0]       AGE_ONE   = {{(AGE_NBITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_READ   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_NOTIFY = 3'd4
    } state_t;

    state_t                       state_q, state_d, adv_state_s;
    logic [FLOW_ADDR_NBITS-1:0]   ptr_q, ptr_d;
    logic                         pending_q, pending_d;
    logic                         refreshed_q, refreshed_d;
    logic                         rd_valid_q, rd_valid_d;
    logic [AGE_NBITS-1:0]         rd_age_q, rd_age_d;
    logic                         aged_valid_q, aged_valid_d;
    logic [FLOW_ADDR_NBITS-1:0]   aged_addr_q, aged_addr_d;
    logic                         init_done_q, init_done_d;
    logic                         busy_q, busy_d;

    logic                         valid_q [DEPTH];
    logic [AGE_NBITS-1:0]         age_q   [DEPTH];

    logic                         any_ref_s, ptr_match_s, last_s, sweeping_s;
    logic                         advance_s, handshake_s, tick_drop_s;
    logic                         sweep_wr_s, sweep_wr_valid_s;
    logic [AGE_NBITS-1:0]         sweep_wr_age_s;
    logic                         wr_en_s, wr_valid_s;
    logic [FLOW_ADDR_NBITS-1:0]   wr_addr_s;
    logic [AGE_NBITS-1:0]         wr_age_s;

    assign any_ref_s   = hit_valid | learn_valid;
    assign ptr_match_s = (hit_valid && (hit_addr == ptr_q)) || (learn_valid && (learn_addr == ptr_q));
    assign last_s      = (ptr_q == LAST_ADDR);
    assign sweeping_s  = (state_q == ST_READ) || (state_q == ST_UPDATE) || (state_q == ST_NOTIFY);
    // A queued or coincident tick chains straight into the next sweep at the wrap.
    assign adv_state_s = (last_s && !pending_q && !tick) ? ST_IDLE : ST_READ;

    // Next-state logic: sequencing, sweep decisions and tick queuing.
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        refreshed_d      = refreshed_q;
        advance_s        = 1'b0;
        handshake_s      = 1'b0;
        sweep_wr_s       = 1'b0;
        sweep_wr_valid_s = 1'b0;
        sweep_wr_age_s   = '0;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + ADDR_ONE;
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_READ;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d     = ST_UPDATE;
                refreshed_d = ptr_match_s;
            end
            ST_UPDATE: begin
                if (refreshed_q || ptr_match_s) begin
                    advance_s = 1'b1;
                    state_d   = adv_state_s;
                    ptr_d     = ptr_q + ADDR_ONE;
                end else if (any_ref_s) begin
                    // Refresh owns the single write port this cycle.
                    state_d = ST_UPDATE;
                end else if (rd_valid_q && (rd_age_q >= aging_time)) begin
                    sweep_wr_s       = 1'b1;
                    sweep_wr_valid_s = 1'b0;
                    state_d          = ST_NOTIFY;
                end else begin
                    sweep_wr_s       = rd_valid_q;
                    sweep_wr_valid_s = 1'b1;
                    sweep_wr_age_s   = rd_age_q + AGE_ONE;
                    advance_s        = 1'b1;
                    state_d          = adv_state_s;
                    ptr_d            = ptr_q + ADDR_ONE;
                end
            end
            ST_NOTIFY: begin
                if (aged_ready) begin
                    handshake_s = 1'b1;
                    advance_s   = 1'b1;
                    state_d     = adv_state_s;
                    ptr_d       = ptr_q + ADDR_ONE;
                end else begin
                    state_d = ST_NOTIFY;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase

        if (advance_s && last_s) begin
            pending_d   = pending_q & tick;
            tick_drop_s = 1'b0;
        end else if (sweeping_s && tick) begin
            pending_d   = 1'b1;
            tick_drop_s = pending_q;
        end else begin
            pending_d   = pending_q;
            tick_drop_s = 1'b0;
        end
    end

    // Output and read-data next values; every output leaves a flop.
    always_comb begin
        busy_d       = (state_d == ST_READ) || (state_d == ST_UPDATE) || (state_d == ST_NOTIFY);
        aged_valid_d = (state_d == ST_NOTIFY);
        if ((state_q == ST_UPDATE) && (state_d == ST_NOTIFY)) begin
            aged_addr_d = ptr_q;
        end else begin
            aged_addr_d = aged_addr_q;
        end
        if ((state_q == ST_INIT) && last_s) begin
            init_done_d = 1'b1;
        end else begin
            init_done_d = init_done_q;
        end
        if (state_q == ST_READ) begin
            rd_valid_d = valid_q[ptr_q];
            rd_age_d   = age_q[ptr_q];
        end else begin
            rd_valid_d = rd_valid_q;
            rd_age_d   = rd_age_q;
        end
    end

    // Single table write port: clear during INIT, then refresh, then sweep.
    always_comb begin
        if (state_q == ST_INIT) begin
            wr_en_s    = 1'b1;
            wr_addr_s  = ptr_q;
            wr_valid_s = 1'b0;
            wr_age_s   = '0;
        end else if (learn_valid) begin
            wr_en_s    = 1'b1;
            wr_addr_s  = learn_addr;
            wr_valid_s = 1'b1;
            wr_age_s   = '0;
        end else if (hit_valid && valid_q[hit_addr]) begin
            wr_en_s    = 1'b1;
            wr_addr_s  = hit_addr;
            wr_valid_s = 1'b1;
            wr_age_s   = '0;
        end else begin
            wr_en_s    = sweep_wr_s;
            wr_addr_s  = ptr_q;
            wr_valid_s = sweep_wr_valid_s;
            wr_age_s   = sweep_wr_age_s;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            pending_q    <= 1'b0;
            refreshed_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_age_q     <= '0;
            aged_valid_q <= 1'b0;
            aged_addr_q  <= '0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            refreshed_q  <= refreshed_d;
            rd_valid_q   <= rd_valid_d;
            rd_age_q     <= rd_age_d;
            aged_valid_q <= aged_valid_d;
            aged_addr_q  <= aged_addr_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
        end
    end

    // Entry table storage; contents are defined by the INIT pass.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            valid_q[wr_addr_s] <= wr_valid_s;
            age_q[wr_addr_s]   <= wr_age_s;
        end
    end

    assign aged_valid = aged_valid_q;
    assign aged_addr  = aged_addr_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;

`ifdef CLASSIFIER_AGING_STATS_EN
    logic        overrun_q;
    logic [31:0] aged_cnt_q;

    // Sticky dropped-tick flag and wrapping expiry counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            aged_cnt_q <= 32'd0;
        end else begin
            overrun_q  <= overrun_q | tick_drop_s;
            aged_cnt_q <= aged_cnt_q + {31'd0, handshake_s};
        end
    end

    assign overrun  = overrun_q;
    assign aged_cnt = aged_cnt_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = tick_drop_s ^ handshake_s;
    assign overrun        = 1'b0;
    assign aged_cnt       = 32'd0;
`endif

endmodule

// File: tb/tb_classifier_aging.sv
// tb_classifier_aging: directed plus randomized checks of classifier_aging against a per-entry
// valid/age reference model updated one whole sweep at a time.
module tb_classifier_aging;

    localparam int N     = 4;
    localparam int A     = 4;
    localparam int DEPTH = 16;
`ifdef CLASSIFIER_AGING_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [A-1:0]  aging_time;
    logic          tick;
    logic          hit_valid;
    logic [N-1:0]  hit_addr;
    logic          learn_valid;
    logic [N-1:0]  learn_addr;
    logic          aged_valid;
    logic [N-1:0]  aged_addr;
    logic          aged_ready;
    logic          init_done;
    logic          busy;
    logic          overrun;
    logic [31:0]   aged_cnt;

    classifier_aging #(.FLOW_ADDR_NBITS(N), .AGE_NBITS(A)) dut (
        .clk(clk), .rst(rst), .aging_time(aging_time), .tick(tick),
        .hit_valid(hit_valid), .hit_addr(hit_addr),
        .learn_valid(learn_valid), .learn_addr(learn_addr),
        .aged_valid(aged_valid), .aged_addr(aged_addr), .aged_ready(aged_ready),
        .init_done(init_done), .busy(busy), .overrun(overrun), .aged_cnt(aged_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: table contents and the expiry order of the current sweep.
    bit m_valid [DEPTH];
    int m_age   [DEPTH];
    int m_at;
    int m_total;
    int exp_q[$];

    int busy_cycles, guard, nops, addr, r;

    function automatic void m_learn(input int a);
        m_valid[a] = 1'b1;
        m_age[a]   = 0;
    endfunction

    function automatic void m_hit(input int a);
        if (m_valid[a]) m_age[a] = 0;
    endfunction

    function automatic void m_sweep(input int skip);
        for (int i = 0; i < DEPTH; i++) begin
            if (i != skip && m_valid[i]) begin
                if (m_age[i] >= m_at) begin
                    m_valid[i] = 1'b0;
                    exp_q.push_back(i);
                    m_total++;
                end else begin
                    m_age[i]++;
                end
            end
        end
    endfunction

    function automatic int exp_cnt(input int held_back);
        return STATS_EN ? (m_total - held_back) : 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_learn(input int a);
        learn_valid = 1'b1;
        learn_addr  = a[N-1:0];
        cyc();
        learn_valid = 1'b0;
        m_learn(a);
    endtask

    task automatic do_hit(input int a);
        hit_valid = 1'b1;
        hit_addr  = a[N-1:0];
        cyc();
        hit_valid = 1'b0;
        m_hit(a);
    endtask

    task automatic set_at(input int t);
        aging_time = t[A-1:0];
        m_at       = t;
    endtask

    task automatic start_sweep();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("tick_to_busy", {31'd0, busy}, 32'd1);
    endtask

    // Collect delivered notifications under random backpressure and compare with the model.
    task automatic drain(input int pct);
        int got[$];
        int cycles;
        cycles = 0;
        while ((busy || aged_valid) && cycles < 1000) begin
            aged_ready = ($urandom_range(0, 99) < pct);
            if (aged_valid && aged_ready) got.push_back(int'(aged_addr));
            cyc();
            cycles++;
        end
        aged_ready = 1'b0;
        check("sweep_done", (cycles < 1000) ? 32'd1 : 32'd0, 32'd1);
        check("aged_num", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check("aged_addr_seq", got[i], exp_q[i]);
        end
        exp_q = {};
        check("aged_cnt", aged_cnt, exp_cnt(0));
    endtask

    task automatic sweep(input int pct);
        start_sweep();
        m_sweep(-1);
        drain(pct);
    endtask

    initial begin
        rst = 1'b1; aging_time = '0; tick = 1'b0; hit_valid = 1'b0; hit_addr = '0;
        learn_valid = 1'b0; learn_addr = '0; aged_ready = 1'b0;
        m_at = 0; m_total = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_age[i]   = 0;
        end
        repeat (3) cyc();
        check("rst_aged_valid", {31'd0, aged_valid}, 32'd0);
        check("rst_aged_addr", {28'd0, aged_addr}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_aged_cnt", aged_cnt, 32'd0);

        // INIT: 16 cycles; a tick and a learn to an already-cleared entry are ignored.
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            tick        = (k == 5);
            learn_valid = (k == 10);
            learn_addr  = '0;
            cyc();
            check("init_busy", {31'd0, busy}, 32'd0);
            check("init_done_timing", {31'd0, init_done}, (k == DEPTH) ? 32'd1 : 32'd0);
        end
        tick = 1'b0; learn_valid = 1'b0;

        // Tick overload on an empty table: two back-to-back sweeps, third tick dropped.
        busy_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            tick = (k % 2 == 0);
            cyc();
            if (busy) busy_cycles++;
        end
        tick = 1'b0;
        guard = 0;
        while (busy && guard < 500) begin
            cyc();
            guard++;
            if (busy) busy_cycles++;
        end
        m_sweep(-1);
        m_sweep(-1);
        check("overload_busy_cycles", busy_cycles, 32'd64);
        check("overload_no_notify", {31'd0, aged_valid}, 32'd0);
        check("overrun", {31'd0, overrun}, {31'd0, STATS_EN});

        // Expiry: entry 5 ages out on the third sweep with aging_time 2.
        do_learn(5);
        set_at(2);
        repeat (3) sweep(100);

        // Hit refresh keeps entry 3 alive; it then expires once hits stop.
        do_learn(3);
        set_at(1);
        for (int k = 0; k < 4; k++) begin
            do_hit(3);
            sweep(100);
        end
        sweep(100);
        sweep(100);

        // Backpressure: notification for 2 held stable while the sweep waits.
        do_learn(2);
        do_learn(9);
        set_at(0);
        start_sweep();
        m_sweep(-1);
        guard = 0;
        while (!aged_valid && guard < 100) begin
            cyc();
            guard++;
        end
        check("bp_valid_seen", {31'd0, aged_valid}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("bp_hold_valid", {31'd0, aged_valid}, 32'd1);
            check("bp_hold_addr", {28'd0, aged_addr}, 32'd2);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        check("bp_cnt_frozen", aged_cnt, exp_cnt(2));
        drain(100);

        // Refresh race: hit to entry 7 during its own READ with age == aging_time.
        do_learn(7);
        set_at(2);
        sweep(100);
        sweep(100);
        start_sweep();
        repeat (14) cyc();
        hit_valid = 1'b1;
        hit_addr  = 4'd7;
        cyc();
        hit_valid = 1'b0;
        m_hit(7);
        m_sweep(7);
        drain(100);
        repeat (3) sweep(100);

        // Randomized refresh mix, thresholds and backpressure.
        for (r = 0; r < 10; r++) begin
            nops = $urandom_range(1, 6);
            for (int j = 0; j < nops; j++) begin
                addr = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) do_learn(addr);
                else do_hit(addr);
            end
            set_at($urandom_range(0, 3));
            sweep($urandom_range(30, 100));
        end

        check("overrun_sticky", {31'd0, overrun}, {31'd0, STATS_EN});
        check("final_aged_cnt", aged_cnt, exp_cnt(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
